adc_read_multich: RTL and testbench

//  Multi-channel successor of the single-channel ADC reader. Captures INT_CHANNELS parallel ADC

---
 rtl/adc_read_multich.sv | 156 +++++++++++++++
 tb/tb_adc_read_multich.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_read_multich.sv
`default_nettype none
//============================================================================
// Module      : adc_read_multich
// Description : Multi-channel ADC capture with polarity/encoding fix-up,
//               optional 2**D block averaging and sticky full-scale flags.
// Revision    : 1.0 - initial multi-channel release
//============================================================================
module adc_read_multich #(
    parameter int INT_CHANNELS             = 2,
    parameter int INT_ADC_DATA_WIDTH       = 10,
    parameter int INT_ADC_DATA_IS_INVERTED = 1,
    parameter int INT_IDATA_ENC_OFFSETBIN  = 1,
    parameter int INT_IDATA_ENC_TWOSCOMPL  = 0,
    parameter int INT_ODATA_ENC_OFFSETBIN  = 1,
    parameter int INT_ODATA_ENC_TWOSCOMPL  = 0,
    parameter int INT_DECIM_LOG2           = 0
) (
    input  logic                                         in_clk,
    input  logic                                         in_rst_n,
    input  logic [INT_CHANNELS*INT_ADC_DATA_WIDTH-1:0]   in_data,
    input  logic                                         in_dready,
    input  logic                                         in_ovr_clr,
    output logic [INT_CHANNELS*INT_ADC_DATA_WIDTH-1:0]   out_data,
    output logic                                         out_valid,
    output logic [INT_CHANNELS-1:0]                      out_ovr
);

    localparam int c_w  = INT_ADC_DATA_WIDTH;
    localparam int c_ch = INT_CHANNELS;
    localparam int c_d  = INT_DECIM_LOG2;

    localparam logic signed [c_w-1:0] c_max = {1'b0, {(c_w-1){1'b1}}};
    localparam logic signed [c_w-1:0] c_min = {1'b1, {(c_w-1){1'b0}}};
    localparam logic [c_w-1:0] c_zero_enc = (INT_ODATA_ENC_OFFSETBIN != 0) ? c_min : '0;

    generate
        if ((INT_IDATA_ENC_OFFSETBIN + INT_IDATA_ENC_TWOSCOMPL) != 1) begin : g_bad_ienc
            $error("adc_read_multich: exactly one input encoding must be selected");
        end
        if ((INT_ODATA_ENC_OFFSETBIN + INT_ODATA_ENC_TWOSCOMPL) != 1) begin : g_bad_oenc
            $error("adc_read_multich: exactly one output encoding must be selected");
        end
    endgenerate

    // Raw ADC word to internal signed value; negating the most negative code saturates.
    function automatic logic signed [c_w-1:0] to_int(input logic [c_w-1:0] raw);
        logic signed [c_w-1:0] v;
        v = (INT_IDATA_ENC_OFFSETBIN != 0) ? {~raw[c_w-1], raw[c_w-2:0]} : raw;
        if (INT_ADC_DATA_IS_INVERTED != 0) begin
            v = (v == c_min) ? c_max : -v;
        end
        return v;
    endfunction

    function automatic logic [c_w-1:0] encode(input logic signed [c_w-1:0] s);
        return (INT_ODATA_ENC_OFFSETBIN != 0) ? {~s[c_w-1], s[c_w-2:0]} : s;
    endfunction

    logic signed [c_w-1:0]  r_s [c_ch];
    logic                   r_v1;
    logic [c_ch-1:0]        r_ovr;
    logic [c_ch-1:0]        w_fs;
    logic [c_ch*c_w-1:0]    r_out;
    logic                   r_valid;

    always_comb begin
        w_fs = '0;
        for (int k = 0; k < c_ch; k++) begin
            w_fs[k] = (r_s[k] == c_max) || (r_s[k] == c_min);
        end
    end

    // Stage 1 capture plus sticky overrange; a new hit outranks a clear on the same edge.
    always_ff @(posedge in_clk) begin
        if (!in_rst_n) begin
            r_v1  <= 1'b0;
            r_ovr <= '0;
            for (int k = 0; k < c_ch; k++) begin
                r_s[k] <= '0;
            end
        end else begin
            r_v1  <= in_dready;
            r_ovr <= (r_v1 ? w_fs : '0) | (r_ovr & ~{c_ch{in_ovr_clr}});
            if (in_dready) begin
                for (int k = 0; k < c_ch; k++) begin
                    r_s[k] <= to_int(in_data[k*c_w +: c_w]);
                end
            end
        end
    end

    generate
        if (c_d == 0) begin : g_bypass
            always_ff @(posedge in_clk) begin
                if (!in_rst_n) begin
                    r_valid <= 1'b0;
                    for (int k = 0; k < c_ch; k++) begin
                        r_out[k*c_w +: c_w] <= c_zero_enc;
                    end
                end else begin
                    r_valid <= r_v1;
                    if (r_v1) begin
                        for (int k = 0; k < c_ch; k++) begin
                            r_out[k*c_w +: c_w] <= encode(r_s[k]);
                        end
                    end
                end
            end
        end else begin : g_decim
            logic [c_d-1:0]             r_cnt;
            logic signed [c_w+c_d-1:0]  r_acc [c_ch];
            logic signed [c_w+c_d-1:0]  w_sum [c_ch];

            always_comb begin
                for (int k = 0; k < c_ch; k++) begin
                    w_sum[k] = r_acc[k] + {{c_d{r_s[k][c_w-1]}}, r_s[k]};
                end
            end

            // Top W bits of the sum are the floor of the block mean.
            always_ff @(posedge in_clk) begin
                if (!in_rst_n) begin
                    r_valid <= 1'b0;
                    r_cnt   <= '0;
                    for (int k = 0; k < c_ch; k++) begin
                        r_out[k*c_w +: c_w] <= c_zero_enc;
                        r_acc[k]            <= '0;
                    end
                end else begin
                    r_valid <= 1'b0;
                    if (r_v1) begin
                        if (r_cnt == {c_d{1'b1}}) begin
                            r_valid <= 1'b1;
                            r_cnt   <= '0;
                            for (int k = 0; k < c_ch; k++) begin
                                r_out[k*c_w +: c_w] <= encode(w_sum[k][c_w+c_d-1:c_d]);
                                r_acc[k]            <= '0;
                            end
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                            for (int k = 0; k < c_ch; k++) begin
                                r_acc[k] <= w_sum[k];
                            end
                        end
                    end
                end
            end
        end
    endgenerate

    assign out_data  = r_out;
    assign out_valid = r_valid;
    assign out_ovr   = r_ovr;

endmodule
`default_nettype wire

// File: tb/tb_adc_read_multich.sv
`default_nettype none
//============================================================================
// Module      : tb_adc_read_multich
// Description : Scoreboard bench for adc_read_multich over four parameter sets.
// Revision    : 1.0 - initial release
//============================================================================
module tb_adc_read_multich;

    logic        in_clk = 1'b0;
    logic        rst_n;
    logic [19:0] din;
    logic        rdy_a, rdy_b, rdy_c, rdy_d;
    logic        clr_a, clr_b, clr_c, clr_d;
    logic [19:0] od_a, od_b, od_c, od_d;
    logic        ov_a, ov_b, ov_c, ov_d;
    logic [1:0]  oo_a, oo_b, oo_c, oo_d;

    int total = 0;
    int bad   = 0;
    int pc_a = 0, pc_b = 0, pc_c = 0, pc_d = 0;
    logic [19:0] exp_q [$];

    always #5 in_clk = ~in_clk;

    always @(negedge in_clk) begin
        if (ov_a === 1'b1) pc_a++;
        if (ov_b === 1'b1) pc_b++;
        if (ov_c === 1'b1) pc_c++;
        if (ov_d === 1'b1) pc_d++;
    end

    // a: bypass, no inversion; b: bypass, inverted; c: D=2 two's compl; d: D=2 offset bin
    adc_read_multich #(.INT_CHANNELS(2), .INT_ADC_DATA_WIDTH(10), .INT_ADC_DATA_IS_INVERTED(0),
        .INT_IDATA_ENC_OFFSETBIN(1), .INT_IDATA_ENC_TWOSCOMPL(0), .INT_ODATA_ENC_OFFSETBIN(1),
        .INT_ODATA_ENC_TWOSCOMPL(0), .INT_DECIM_LOG2(0)) u_a (
        .in_clk(in_clk), .in_rst_n(rst_n), .in_data(din), .in_dready(rdy_a), .in_ovr_clr(clr_a),
        .out_data(od_a), .out_valid(ov_a), .out_ovr(oo_a));
    adc_read_multich #(.INT_CHANNELS(2), .INT_ADC_DATA_WIDTH(10), .INT_ADC_DATA_IS_INVERTED(1),
        .INT_IDATA_ENC_OFFSETBIN(1), .INT_IDATA_ENC_TWOSCOMPL(0), .INT_ODATA_ENC_OFFSETBIN(1),
        .INT_ODATA_ENC_TWOSCOMPL(0), .INT_DECIM_LOG2(0)) u_b (
        .in_clk(in_clk), .in_rst_n(rst_n), .in_data(din), .in_dready(rdy_b), .in_ovr_clr(clr_b),
        .out_data(od_b), .out_valid(ov_b), .out_ovr(oo_b));
    adc_read_multich #(.INT_CHANNELS(2), .INT_ADC_DATA_WIDTH(10), .INT_ADC_DATA_IS_INVERTED(0),
        .INT_IDATA_ENC_OFFSETBIN(0), .INT_IDATA_ENC_TWOSCOMPL(1), .INT_ODATA_ENC_OFFSETBIN(0),
        .INT_ODATA_ENC_TWOSCOMPL(1), .INT_DECIM_LOG2(2)) u_c (
        .in_clk(in_clk), .in_rst_n(rst_n), .in_data(din), .in_dready(rdy_c), .in_ovr_clr(clr_c),
        .out_data(od_c), .out_valid(ov_c), .out_ovr(oo_c));
    adc_read_multich #(.INT_CHANNELS(2), .INT_ADC_DATA_WIDTH(10), .INT_ADC_DATA_IS_INVERTED(0),
        .INT_IDATA_ENC_OFFSETBIN(1), .INT_IDATA_ENC_TWOSCOMPL(0), .INT_ODATA_ENC_OFFSETBIN(1),
        .INT_ODATA_ENC_TWOSCOMPL(0), .INT_DECIM_LOG2(2)) u_d (
        .in_clk(in_clk), .in_rst_n(rst_n), .in_data(din), .in_dready(rdy_d), .in_ovr_clr(clr_d),
        .out_data(od_d), .out_valid(ov_d), .out_ovr(oo_d));

    task automatic tick;
        @(posedge in_clk);
        #1;
    endtask

    // Reference model works on integers rather than bit manipulation.
    function automatic int mval(input logic [9:0] raw, input bit iob, input bit inv);
        int v;
        if (iob) v = int'(raw) - 512;
        else     v = (raw >= 10'd512) ? int'(raw) - 1024 : int'(raw);
        if (inv) begin
            v = -v;
            if (v > 511) v = 511;
        end
        return v;
    endfunction

    function automatic logic [9:0] menc(input int v, input bit oob);
        if (oob) return 10'(v + 512);
        return 10'(v);
    endfunction

    function automatic bit mfs(input int v);
        return (v == 511) || (v == -512);
    endfunction

    function automatic logic vld(input int inst);
        case (inst)
            0:       return ov_a;
            1:       return ov_b;
            2:       return ov_c;
            default: return ov_d;
        endcase
    endfunction

    function automatic logic [19:0] dat(input int inst);
        case (inst)
            0:       return od_a;
            1:       return od_b;
            2:       return od_c;
            default: return od_d;
        endcase
    endfunction

    // Called one cycle after the last sample edge; cyc = cycles since that edge.
    task automatic wait_valid(input int inst, input int maxc, output int cyc);
        cyc = 1;
        while (cyc <= maxc && vld(inst) !== 1'b1) begin
            tick;
            cyc++;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; din = '0;
        rdy_a = 0; rdy_b = 0; rdy_c = 0; rdy_d = 0;
        clr_a = 0; clr_b = 0; clr_c = 0; clr_d = 0;
        tick; tick;
        total++; if (od_a !== 20'h80200) begin bad++; $display("FAIL reset_data_a got=%h exp=%h", od_a, 20'h80200); end
        total++; if (od_c !== 20'h00000) begin bad++; $display("FAIL reset_data_c got=%h exp=%h", od_c, 20'h00000); end
        total++; if (od_d !== 20'h80200) begin bad++; $display("FAIL reset_data_d got=%h exp=%h", od_d, 20'h80200); end
        total++; if (ov_a !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", ov_a); end
        total++; if (oo_b !== 2'b00) begin bad++; $display("FAIL reset_ovr got=%b exp=00", oo_b); end
        rst_n = 1'b1;
        tick;
    endtask

    task automatic test_single(input int inst, input logic [9:0] r0, input logic [9:0] r1,
                               input bit inv, input string nm);
        int cyc, pc0;
        logic [1:0] eovr, got_ovr;
        logic [19:0] e;
        exp_q.push_back({menc(mval(r1, 1, inv), 1), menc(mval(r0, 1, inv), 1)});
        eovr = {mfs(mval(r1, 1, inv)), mfs(mval(r0, 1, inv))};
        pc0 = (inst == 0) ? pc_a : pc_b;
        din = {r1, r0};
        if (inst == 0) rdy_a = 1'b1; else rdy_b = 1'b1;
        tick;
        rdy_a = 1'b0; rdy_b = 1'b0;
        wait_valid(inst, 6, cyc);
        e = exp_q.pop_front();
        total++;
        if (cyc > 6) begin
            bad++; $display("FAIL %s_timeout got=no_valid exp=valid", nm);
        end else if (dat(inst) !== e) begin
            bad++; $display("FAIL %s_data got=%h exp=%h", nm, dat(inst), e);
        end
        total++; if (cyc != 2) begin bad++; $display("FAIL %s_latency got=%0d exp=2", nm, cyc); end
        got_ovr = (inst == 0) ? oo_a : oo_b;
        total++; if (got_ovr !== eovr) begin bad++; $display("FAIL %s_ovr got=%b exp=%b", nm, got_ovr, eovr); end
        tick;
        total++;
        if (((inst == 0) ? pc_a : pc_b) - pc0 != 1) begin
            bad++; $display("FAIL %s_pulses got=%0d exp=1", nm, ((inst == 0) ? pc_a : pc_b) - pc0);
        end
    endtask

    task automatic test_decim(input int gap, input string nm);
        int s0 [4] = '{4, 5, 6, 7};
        int s1 [4] = '{-1, -1, -1, -2};
        int sum0, sum1, cyc, pc0;
        logic [19:0] e;
        sum0 = 0; sum1 = 0;
        for (int i = 0; i < 4; i++) begin
            sum0 += mval(10'(s0[i]), 0, 0);
            sum1 += mval(10'(s1[i]), 0, 0);
        end
        exp_q.push_back({menc(sum1 >>> 2, 0), menc(sum0 >>> 2, 0)});
        pc0 = pc_c;
        for (int i = 0; i < 4; i++) begin
            din = {10'(s1[i]), 10'(s0[i])};
            rdy_c = 1'b1;
            tick;
            rdy_c = 1'b0;
            if (i < 3) begin
                repeat (gap) tick;
                total++; if (pc_c != pc0) begin bad++; $display("FAIL %s_early s%0d got=%0d exp=0", nm, i, pc_c - pc0); end
            end
        end
        wait_valid(2, 6, cyc);
        e = exp_q.pop_front();
        total++;
        if (cyc > 6) begin
            bad++; $display("FAIL %s_timeout got=no_valid exp=valid", nm);
        end else if (od_c !== e) begin
            bad++; $display("FAIL %s_data got=%h exp=%h", nm, od_c, e);
        end
        total++; if (cyc != 2) begin bad++; $display("FAIL %s_latency got=%0d exp=2", nm, cyc); end
        tick; tick;
        total++; if (pc_c - pc0 != 1) begin bad++; $display("FAIL %s_pulses got=%0d exp=1", nm, pc_c - pc0); end
    endtask

    task automatic test_reset_midblock;
        int cyc, pc0;
        logic [19:0] e;
        pc0 = pc_d;
        din = {10'h264, 10'h264};
        rdy_d = 1'b1;
        tick; tick;
        rdy_d = 1'b0;
        tick; tick;
        rst_n = 1'b0;
        tick;
        rst_n = 1'b1;
        total++; if (od_d !== 20'h80200) begin bad++; $display("FAIL midrst_data got=%h exp=%h", od_d, 20'h80200); end
        total++; if (oo_d !== 2'b00) begin bad++; $display("FAIL midrst_ovr got=%b exp=00", oo_d); end
        exp_q.push_back({menc(mval(10'h208, 1, 0), 1), menc(mval(10'h208, 1, 0), 1)});
        din = {10'h208, 10'h208};
        rdy_d = 1'b1;
        repeat (4) tick;
        rdy_d = 1'b0;
        wait_valid(3, 6, cyc);
        e = exp_q.pop_front();
        total++;
        if (cyc > 6) begin
            bad++; $display("FAIL midrst_timeout got=no_valid exp=valid");
        end else if (od_d !== e) begin
            bad++; $display("FAIL midrst_result got=%h exp=%h", od_d, e);
        end
        total++; if (cyc != 2) begin bad++; $display("FAIL midrst_latency got=%0d exp=2", cyc); end
        tick; tick;
        total++; if (pc_d - pc0 != 1) begin bad++; $display("FAIL midrst_pulses got=%0d exp=1", pc_d - pc0); end
    endtask

    task automatic test_ovr_clr;
        logic [1:0]  eovr;
        logic [19:0] e;
        clr_a = 1'b1;
        tick;
        clr_a = 1'b0;
        total++; if (oo_a !== 2'b00) begin bad++; $display("FAIL ovr_clear1 got=%b exp=00", oo_a); end
        exp_q.push_back({menc(mval(10'h200, 1, 0), 1), menc(mval(10'h3FF, 1, 0), 1)});
        eovr = {mfs(mval(10'h200, 1, 0)), mfs(mval(10'h3FF, 1, 0))};
        din = {10'h200, 10'h3FF};
        rdy_a = 1'b1; clr_a = 1'b1;
        tick;
        rdy_a = 1'b0;
        tick;
        clr_a = 1'b0;
        e = exp_q.pop_front();
        total++; if (ov_a !== 1'b1 || od_a !== e) begin bad++; $display("FAIL ovr_out got=%b/%h exp=1/%h", ov_a, od_a, e); end
        total++; if (oo_a !== eovr) begin bad++; $display("FAIL ovr_setwins got=%b exp=%b", oo_a, eovr); end
        tick; tick;
        total++; if (oo_a !== eovr) begin bad++; $display("FAIL ovr_sticky got=%b exp=%b", oo_a, eovr); end
        clr_a = 1'b1;
        tick;
        clr_a = 1'b0;
        total++; if (oo_a !== 2'b00) begin bad++; $display("FAIL ovr_clear2 got=%b exp=00", oo_a); end
    endtask

    task automatic test_back_to_back;
        int pops;
        logic [9:0]  r0, r1;
        logic [19:0] e;
        pops = 0;
        for (int i = 0; i < 16; i++) begin
            if (i < 12) begin
                r0 = 10'($urandom_range(0, 1023));
                r1 = 10'($urandom_range(0, 1023));
                din = {r1, r0};
                rdy_a = 1'b1;
                exp_q.push_back({menc(mval(r1, 1, 0), 1), menc(mval(r0, 1, 0), 1)});
            end else begin
                rdy_a = 1'b0;
            end
            tick;
            if (ov_a === 1'b1) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++; $display("FAIL b2b_extra got=%h exp=none", od_a);
                end else begin
                    e = exp_q.pop_front();
                    pops++;
                    if (od_a !== e) begin bad++; $display("FAIL b2b_data #%0d got=%h exp=%h", pops, od_a, e); end
                end
            end
        end
        total++; if (pops != 12) begin bad++; $display("FAIL b2b_count got=%0d exp=12", pops); end
        exp_q.delete();
    endtask

    initial begin
        test_reset;
        test_single(0, 10'h200, 10'h3FF, 1'b0, "single");
        test_single(1, 10'h000, 10'h201, 1'b1, "invert");
        test_decim(0, "decim");
        test_decim(3, "decim_gap");
        test_reset_midblock;
        test_ovr_clr;
        test_back_to_back;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
